timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Shares one fixed-period one-shot timer among M requesters. Grants requesters in round-robin order and fires the timer's START. Waits for the timer's RDY pulse, then returns a one-cycle DONE to the granted requester. A watchdog flags ERR if RDY never arrives. It sits between client FSMs and the shared timer, and is the only block allowed to drive the timer's START.

## Interface
- M, default 4: number of requesters, 2..16.
- TIMEOUT, default 64: cycles in WAIT without RDY before ERR; must exceed the timer period + 1.
- CLK  in  1  clock; all state updates on the rising edge.
- N_RESET  in  1  reset, asynchronous, active-low.
- REQ  in  M  level request per requester; sampled only in IDLE.
- GNT  out  M  one-hot grant; held from START through DONE/ERR inclusive.
- DONE  out  M  one-cycle pulse to the granted requester on timer expiry.
- ERR  out  1  one-cycle pulse on watchdog expiry; GNT identifies the victim.
- BUSY  out  1  high whenever state ≠ IDLE.
- TMR_START  out  1  to the timer's START; high exactly one cycle per grant.
- TMR_RDY  in  1  from the timer's RDY; one-cycle pulse at expiry.

## Operation
- States (one-hot enum): IDLE, FIRE, WAIT, DONE, ERR. Unknown encodings go to IDLE.
- IDLE:
  - If REQ ≠ 0, choose the winner by searching from ptr upward, wrapping at M-1→0.
  - Register the winner index in sel. Go to FIRE.
  - If REQ = 0, stay in IDLE.
- FIRE: TMR_START=1, watchdog wd cleared to 0. Go to WAIT unconditionally.
- WAIT:
  - If TMR_RDY=1, go to DONE.
  - Else if wd = TIMEOUT-1, go to ERR.
  - Else wd increments.
  - RDY and the timeout condition in the same cycle: RDY wins, go to DONE.
- DONE: DONE[sel]=1. ptr ← (sel+1) mod M. Go to IDLE.
- ERR: ERR=1, DONE stays 0. ptr ← (sel+1) mod M. Go to IDLE.
- GNT[sel]=1 in FIRE, WAIT, DONE and ERR; 0 in IDLE.
- TMR_RDY outside WAIT is ignored, including a stray pulse in FIRE or IDLE.
- REQ deasserting while granted is ignored; the service completes and DONE still pulses.
- A requester holding REQ through its DONE is eligible again, but only after all other active requesters have been served.
- wd width is $clog2(TIMEOUT). Wrap is impossible because the compare terminates first.
- Reset mid-operation: everything returns to the reset values immediately. A timer already started is not cancelled, and its late RDY is ignored in IDLE.
- Reset values: state=IDLE, ptr=0, sel=0, wd=0; GNT=0, DONE=0, ERR=0, BUSY=0, TMR_START=0.

## Timing
- All outputs are decoded from registered state and sel only, with no combinational path from REQ or TMR_RDY.
- REQ seen in IDLE in cycle t gives:
  - FIRE in cycle t+1, with TMR_START and GNT high;
  - WAIT from t+2.
- With the team timer of period N (RDY pulse N cycles after START is sampled):
  - RDY arrives in cycle t+1+N;
  - DONE pulses in cycle t+2+N;
  - IDLE in cycle t+3+N.
- Back-to-back service: the next grant's FIRE is at t+4+N. Per-grant occupancy is N+3 cycles.
- Timeout: ERR pulses in cycle t+2+TIMEOUT.
- One-cycle gap after every ERR pulse and every DONE pulse, so no two DONE pulses are ever adjacent.

## Structure
- Package timer_sched_pkg holds:
  - state_t enum (IDLE='b00001, FIRE='b00010, WAIT='b00100, DONE='b01000, ERR='b10000);
  - the helper function for the index width.
- Sub-module rr_picker (combinational, parameter M):
  - inputs REQ and ptr;
  - outputs valid and index of the first set bit at or after ptr, with wrap.
- Top level holds the FSM, the sel/ptr/wd registers and the output decode.

## Test plan
- Single request, M=4, timer N=8: REQ=0b0100 at t → TMR_START at t+1, GNT=0b0100 for t+1..t+10, DONE=0b0100 at t+10 only, BUSY low at t+11.
- Fairness: REQ=0b1111 held, ptr=0 → grant order 0,1,2,3,0. No grant is skipped or repeated, and exactly one TMR_START per grant.
- Watchdog: TIMEOUT=16, timer model never answers → ERR at t+18, DONE stays 0, next grant goes to the next index.
- Race: RDY asserted in the same cycle wd=TIMEOUT-1 → DONE pulses, ERR stays 0.
- Robustness:
  - stray TMR_RDY in IDLE and in FIRE is ignored;
  - REQ dropped during WAIT still gets DONE;
  - N_RESET pulsed in WAIT → all outputs 0 asynchronously, and a late RDY after release produces no DONE.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the round-robin timer scheduler.
package timer_sched_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_FIRE = 5'b00010,
    ST_WAIT = 5'b00100,
    ST_DONE = 5'b01000,
    ST_ERR  = 5'b10000
  } state_t;

  // Index width that stays at least one bit wide for tiny counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_picker
  import timer_sched_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0]          req,
  input  logic [idx_w(M)-1:0]   ptr,
  output logic                  valid,
  output logic [idx_w(M)-1:0]   index
);

  localparam int IW = idx_w(M);

  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < M; i++) begin
      j = int'(ptr) + i;
      if (j >= M) j = j - M;
      if (!valid && req[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Arbitrates M requesters onto one shared one-shot timer with a RDY watchdog.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int M       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [M-1:0] REQ,
  output logic [M-1:0] GNT,
  output logic [M-1:0] DONE,
  output logic         ERR,
  output logic         BUSY,
  output logic         TMR_START,
  input  logic         TMR_RDY
);

  localparam int IW = idx_w(M);
  localparam int WW = idx_w(TIMEOUT);

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   sel_nxt;
  logic [M-1:0]    sel_oh;

  rr_picker #(.M(M)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .index (pick_idx)
  );

  assign sel_nxt = (sel_q == IW'(M - 1)) ? '0 : sel_q + IW'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        sel_d   = pick_idx;
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      // RDY is checked first so it beats a simultaneous watchdog expiry.
      ST_WAIT: begin
        if (TMR_RDY)                         state_d = ST_DONE;
        else if (wd_q == WW'(TIMEOUT - 1))   state_d = ST_ERR;
        else                                 wd_d    = wd_q + WW'(1);
      end
      ST_DONE, ST_ERR: begin
        ptr_d   = sel_nxt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Outputs depend only on registered state/sel, never on REQ or TMR_RDY.
  assign sel_oh    = {{(M-1){1'b0}}, 1'b1} << sel_q;
  assign GNT       = (state_q == ST_FIRE || state_q == ST_WAIT ||
                      state_q == ST_DONE || state_q == ST_ERR) ? sel_oh : '0;
  assign DONE      = (state_q == ST_DONE) ? sel_oh : '0;
  assign ERR       = (state_q == ST_ERR);
  assign BUSY      = (state_q != ST_IDLE);
  assign TMR_START = (state_q == ST_FIRE);

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a period-8 timer model, M=4, TIMEOUT=16.
module tb_timer_scheduler;

  localparam int M  = 4;
  localparam int TO = 16;
  localparam int N  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [M-1:0] req = '0;
  logic [M-1:0] gnt, done;
  logic         err, busy, tmr_start, tmr_rdy;
  logic         tm_en = 1'b0;
  logic         stray = 1'b0;
  int           tm_cnt = 0;
  int           n_start = 0;
  int           adj = 0;
  logic [M-1:0] prev_done = '0;
  int           checks = 0;
  int           failures = 0;

  timer_scheduler #(.M(M), .TIMEOUT(TO)) dut (
    .CLK       (clk),
    .N_RESET   (rst_n),
    .REQ       (req),
    .GNT       (gnt),
    .DONE      (done),
    .ERR       (err),
    .BUSY      (busy),
    .TMR_START (tmr_start),
    .TMR_RDY   (tmr_rdy)
  );

  always #5 clk = ~clk;

  // Timer model: RDY pulses N cycles after START is sampled; unaffected by N_RESET.
  always @(posedge clk) begin
    if (tmr_start)       tm_cnt <= N;
    else if (tm_cnt > 0) tm_cnt <= tm_cnt - 1;
  end
  assign tmr_rdy = (tm_en && tm_cnt == 1) || stray;

  always @(posedge clk) begin
    if (tmr_start) n_start <= n_start + 1;
    prev_done <= done;
    if (prev_done != '0 && done != '0) adj <= adj + 1;
  end

  typedef struct {
    logic [M-1:0] req;
    logic [M-1:0] gnt;
    logic [M-1:0] done;
    logic         err;
    logic         busy;
    logic         start;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    stray = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output logic [M-1:0] g);
    g = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tmr_start) begin
        g = gnt;
        return;
      end
    end
    chk("start_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [M-1:0] g;
    logic [M-1:0] order [5];
    logic         bad;
    int           s0;

    for (int i = 0; i < 12; i++) tbl[i] = '{req: '0, gnt: 4'b0100, done: '0, err: 1'b0, busy: 1'b1, start: 1'b0};
    tbl[0]  = '{req: 4'b0100, gnt: '0, done: '0, err: 1'b0, busy: 1'b0, start: 1'b0};
    tbl[1].start = 1'b1;
    tbl[10].done = 4'b0100;
    tbl[11] = '{req: '0, gnt: '0, done: '0, err: 1'b0, busy: 1'b0, start: 1'b0};
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {gnt, done, err, busy, tmr_start}, 32'd0);
    rst_n = 1'b1;

    // Single request trace, cycle by cycle
    tm_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      #1;
      chk($sformatf("single_gnt[%0d]", i),   gnt,       tbl[i].gnt);
      chk($sformatf("single_done[%0d]", i),  done,      tbl[i].done);
      chk($sformatf("single_err[%0d]", i),   err,       tbl[i].err);
      chk($sformatf("single_busy[%0d]", i),  busy,      tbl[i].busy);
      chk($sformatf("single_start[%0d]", i), tmr_start, tbl[i].start);
      @(negedge clk);
    end

    // Fairness with all requests held
    do_reset();
    s0  = n_start;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(g);
      if (i == 4) req = '0;
      chk($sformatf("fair_grant[%0d]", i), g, order[i]);
    end
    repeat (12) @(negedge clk);
    chk("fair_start_count", n_start - s0, 32'd5);

    // Watchdog: timer never answers
    do_reset();
    tm_en = 1'b0;
    req   = 4'b0010;
    bad   = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      req = '0;
      if (k < 18 && err) bad = 1'b1;
    end
    chk("wd_no_early_err", bad, 1'b0);
    chk("wd_err",  err,  1'b1);
    chk("wd_gnt",  gnt,  4'b0010);
    chk("wd_done", done, 4'b0000);
    @(negedge clk);
    chk("wd_gap_busy", busy, 1'b0);
    chk("wd_gap_err",  err,  1'b0);
    req = 4'b1010;
    wait_start(g);
    req = '0;
    chk("wd_next_grant", g, 4'b1000);

    // Race: RDY in the same cycle the watchdog would expire
    do_reset();
    tm_en = 1'b0;
    req   = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      req = '0;
    end
    stray = 1'b1;
    chk("race_err_pre", err, 1'b0);
    @(negedge clk);
    stray = 1'b0;
    chk("race_done", done, 4'b0001);
    chk("race_err",  err,  1'b0);
    @(negedge clk);
    chk("race_idle", busy, 1'b0);

    // Stray RDY in IDLE, then in FIRE
    do_reset();
    tm_en = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_idle_busy", busy, 1'b0);
    chk("stray_idle_done", done, 4'b0000);
    req = 4'b0001;
    @(negedge clk);
    req   = '0;
    stray = 1'b1;
    chk("stray_fire_start", tmr_start, 1'b1);
    @(negedge clk);
    stray = 1'b0;
    chk("stray_fire_done", done, 4'b0000);
    chk("stray_fire_busy", busy, 1'b1);
    for (int k = 3; k <= 10; k++) @(negedge clk);
    chk("stray_fire_done_ontime", done, 4'b0001);
    @(negedge clk);
    chk("stray_fire_idle", busy, 1'b0);

    // Reset pulsed during WAIT; late RDY must not produce DONE
    do_reset();
    tm_en = 1'b1;
    req   = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req = '0;
    end
    chk("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {gnt, done, err, busy, tmr_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done != '0 || busy) bad = 1'b1;
    end
    chk("rst_late_rdy_ignored", bad, 1'b0);

    chk("no_adjacent_done", adj, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
